// File: rtl/jk_cmd_driver.sv
// ---------------------------------------------------------------------------
// jk_cmd_driver
//
// Command-driven stimulus stage that sits directly upstream of a JK flip-flop.
// Commands (HOLD/RESET/SET/TOGGLE plus a repeat length) arrive over a
// valid/ready handshake, are buffered in a small circular FIFO, and are then
// played onto registered j/k outputs for cmd_len+1 cycles each. A shadow copy
// of the downstream flop's Q is kept so the flop can be checked against it.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous, active-high reset
//   cmd_valid  : a command is present on cmd_op/cmd_len
//   cmd_ready  : FIFO can accept a command this cycle (low while rst is high)
//   cmd_op     : 0=HOLD(jk=00) 1=RESET(jk=01) 2=SET(jk=10) 3=TOGGLE(jk=11)
//   cmd_len    : drive length minus one
//   j, k       : registered J/K to the downstream flop
//   busy       : FSM is in DRIVE
//   done       : one-cycle pulse after a command's last drive cycle
//   q_model    : shadow Q with standard JK semantics
//   fifo_level : number of queued commands (0..DEPTH)
// ---------------------------------------------------------------------------
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             q_model,
    output logic [LVL_W-1:0] fifo_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W+1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_len;

    // No full-bypass: a pop in the same cycle does not open a slot for a push.
    assign full      = (fifo_level == LVL_W'(DEPTH));
    assign empty     = (fifo_level == '0);
    assign cmd_ready = !rst && !full;
    assign push      = cmd_valid && cmd_ready;

    // The FSM takes the head entry either when idle or on the final cycle of
    // the current command, which gives back-to-back playback with no gap.
    assign pop       = !empty && ((state == IDLE) || (cnt == '0));

    assign {head_op, head_len} = mem[rd_ptr];
    assign busy                = (state == DRIVE);

    // Storage array carries no reset; only the pointers and level define
    // which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_op, cmd_len};
        end
    end

    // FIFO bookkeeping. DEPTH is a power of two so the pointers wrap on their
    // own; the level tracks accepted-but-not-popped entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Playback FSM plus the shadow Q. q_model looks at the j/k currently on
    // the outputs, i.e. exactly what the downstream flop samples at this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            j       <= 1'b0;
            k       <= 1'b0;
            done    <= 1'b0;
            q_model <= 1'b0;
        end else begin
            done <= 1'b0;

            case ({j, k})
                2'b01:   q_model <= 1'b0;
                2'b10:   q_model <= 1'b1;
                2'b11:   q_model <= ~q_model;
                default: q_model <= q_model;
            endcase

            case (state)
                IDLE: begin
                    if (!empty) begin
                        {j, k} <= head_op;
                        cnt    <= head_len;
                        state  <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        done <= 1'b1;
                        if (!empty) begin
                            {j, k} <= head_op;
                            cnt    <= head_len;
                        end else begin
                            j     <= 1'b0;
                            k     <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    j     <= 1'b0;
                    k     <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_driver
//
// Directed bench for jk_cmd_driver (DEPTH=4, CNT_W=4). Inputs are driven 1 ns
// after each rising edge and outputs are sampled at the same point, so every
// vector describes "inputs before edge N" and "outputs after edge N".
// ---------------------------------------------------------------------------
module tb_jk_cmd_driver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;
    logic             j;
    logic             k;
    logic             busy;
    logic             done;
    logic             q_model;
    logic [LVL_W-1:0] fifo_level;

    int asserts  = 0;
    int failures = 0;

    typedef struct {
        logic             rst;
        logic             valid;
        logic [1:0]       op;
        logic [CNT_W-1:0] len;
        logic [1:0]       jk;
        logic             busy;
        logic             done;
        logic             q;
        logic [LVL_W-1:0] lvl;
        logic             ready;
    } vec_t;

    vec_t basic[$];
    vec_t tail[$];

    jk_cmd_driver #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .q_model    (q_model),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                                input logic [CNT_W-1:0] len, input logic [1:0] jk,
                                input logic b, input logic d, input logic q,
                                input logic [LVL_W-1:0] lvl, input logic rdy);
        vec_t t;
        t.rst = r;  t.valid = v; t.op = op; t.len = len;
        t.jk = jk;  t.busy = b;  t.done = d; t.q = q;
        t.lvl = lvl; t.ready = rdy;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] op,
                                 input logic [CNT_W-1:0] len);
        rst       = r;
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = len;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of table stimulus followed by a check of every output.
    task automatic runVector(input string tag, input vec_t v);
        applyStimulus(v.rst, v.valid, v.op, v.len);
        tick();
        checkOutput({tag, "_jk"},    8'({j, k}),     8'(v.jk));
        checkOutput({tag, "_busy"},  8'(busy),       8'(v.busy));
        checkOutput({tag, "_done"},  8'(done),       8'(v.done));
        checkOutput({tag, "_q"},     8'(q_model),    8'(v.q));
        checkOutput({tag, "_level"}, 8'(fifo_level), 8'(v.lvl));
        checkOutput({tag, "_ready"}, 8'(cmd_ready),  8'(v.ready));
    endtask

    // Presents one command and holds it until accepted; returns how many
    // edges it had to wait for cmd_ready. An expired wait is a failure.
    task automatic pushCmd(input logic [1:0] op, input logic [CNT_W-1:0] len,
                           output int waited);
        waited = 0;
        applyStimulus(1'b0, 1'b1, op, len);
        while (!cmd_ready && waited < 64) begin
            tick();
            waited++;
        end
        if (!cmd_ready) begin
            asserts++;
            failures++;
            $display("[TB] FAIL push_timeout: got ready=0 after %0d edges, expected ready=1", waited);
        end else begin
            tick();
        end
        cmd_valid = 1'b0;
    endtask

    initial begin
        int w;

        // Reset, SET len=2, RESET len=0 (q back to 0), TOGGLE len=3,
        // then SET/RESET len=0 back-to-back.
        basic.push_back(mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        basic.push_back(mk(1, 1, 2, 0, 2'b00, 0, 0, 0, 0, 0));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        basic.push_back(mk(0, 1, 2, 2, 2'b00, 0, 0, 0, 1, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b10, 1, 0, 0, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b10, 1, 0, 1, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b10, 1, 0, 1, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 1, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 1));
        basic.push_back(mk(0, 1, 1, 0, 2'b00, 0, 0, 1, 1, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b01, 1, 0, 1, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        basic.push_back(mk(0, 1, 3, 3, 2'b00, 0, 0, 0, 1, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b11, 1, 0, 0, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b11, 1, 0, 0, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b11, 1, 0, 1, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        basic.push_back(mk(0, 1, 2, 0, 2'b00, 0, 0, 0, 1, 1));
        basic.push_back(mk(0, 1, 1, 0, 2'b10, 1, 0, 0, 1, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b01, 1, 1, 1, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1));
        basic.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));

        // Drain of the full-FIFO scenario: B(RESET,1) C(TOGGLE,0) D(SET,2) E(RESET,0).
        tail.push_back(mk(0, 0, 0, 0, 2'b01, 1, 0, 0, 3, 1));
        tail.push_back(mk(0, 0, 0, 0, 2'b11, 1, 1, 0, 2, 1));
        tail.push_back(mk(0, 0, 0, 0, 2'b10, 1, 1, 1, 1, 1));
        tail.push_back(mk(0, 0, 0, 0, 2'b10, 1, 0, 1, 1, 1));
        tail.push_back(mk(0, 0, 0, 0, 2'b10, 1, 0, 1, 1, 1));
        tail.push_back(mk(0, 0, 0, 0, 2'b01, 1, 1, 1, 0, 1));
        tail.push_back(mk(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 1));

        applyStimulus(1'b1, 1'b0, 2'd0, '0);

        for (int i = 0; i < basic.size(); i++) begin
            runVector($sformatf("basic%0d", i), basic[i]);
        end

        // Full FIFO: HOLD len=15 then A..E. A..D fill the FIFO; E must wait
        // until the edge after HOLD finishes and A is popped.
        $display("[TB] full-FIFO scenario");
        pushCmd(2'd0, 4'd15, w);
        pushCmd(2'd2, 4'd0, w);
        pushCmd(2'd1, 4'd1, w);
        pushCmd(2'd3, 4'd0, w);
        pushCmd(2'd2, 4'd2, w);
        checkOutput("full_level", 8'(fifo_level), 8'd4);
        checkOutput("full_ready", 8'(cmd_ready),  8'd0);
        checkOutput("full_busy",  8'(busy),       8'd1);
        checkOutput("full_jk",    8'({j, k}),     8'b00);
        pushCmd(2'd1, 4'd0, w);
        checkOutput("full_wait",   8'(w),          8'd13);
        checkOutput("accE_jk",     8'({j, k}),     8'b01);
        checkOutput("accE_done",   8'(done),       8'd1);
        checkOutput("accE_q",      8'(q_model),    8'd1);
        checkOutput("accE_level",  8'(fifo_level), 8'd3);
        for (int i = 0; i < tail.size(); i++) begin
            runVector($sformatf("drain%0d", i), tail[i]);
        end

        // Reset mid-DRIVE with two commands queued.
        $display("[TB] mid-drive reset scenario");
        pushCmd(2'd3, 4'd15, w);
        pushCmd(2'd2, 4'd0, w);
        pushCmd(2'd1, 4'd0, w);
        checkOutput("pre_rst_busy",  8'(busy),       8'd1);
        checkOutput("pre_rst_level", 8'(fifo_level), 8'd2);
        checkOutput("pre_rst_jk",    8'({j, k}),     8'b11);
        runVector("midrst", mk(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
        runVector("postrst", mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1));
        for (int i = 3; i <= 8; i++) begin
            runVector($sformatf("replay%0d", i), basic[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/jk_cmd_driver.md
Name: jk_cmd_driver

Overview:
- Command-driven stimulus stage that sits directly upstream of the JK flip-flop and drives its J/K inputs.
- Accepts HOLD/RESET/SET/TOGGLE commands with a repeat length over a valid/ready handshake and buffers them in a small FIFO.
- Plays each command onto registered j/k outputs for the requested number of cycles.
- Keeps a shadow model of the downstream flop's Q so the bench can check the flop against it.

Parameters:
DEPTH, 4, command FIFO depth in entries (power of two, >=2)
CNT_W, 4, width of the cmd_len field
LVL_W, $clog2(DEPTH+1), width of fifo_level (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present on cmd_op/cmd_len
cmd_ready  output  1  FIFO can accept a command this cycle
cmd_op  input  2  0=HOLD(jk=00) 1=RESET(jk=01) 2=SET(jk=10) 3=TOGGLE(jk=11)
cmd_len  input  CNT_W  drive length minus one: command drives cmd_len+1 cycles
j  output  1  registered J to the downstream flop
k  output  1  registered K to the downstream flop
busy  output  1  FSM in DRIVE
done  output  1  one-cycle pulse after a command's last drive cycle
q_model  output  1  shadow Q, standard JK semantics
fifo_level  output  LVL_W  number of queued commands (0..DEPTH)

Behaviour:
- Reset (rst high at an edge) clears the following to 0: j, k, busy, done, q_model, fifo_level, FIFO pointers, FSM state (IDLE).
- cmd_ready is 0 in any cycle where rst is high; commands presented during reset are dropped. Reset mid-DRIVE aborts the current command and discards the queue; no done is generated for it.
- Handshake: a command is accepted at an edge where cmd_valid && cmd_ready. cmd_ready = !full, with no full-bypass: when full, a same-cycle pop does not allow a push. cmd_op/cmd_len are don't-care when cmd_valid is low.
- FIFO: circular buffer of DEPTH entries. Simultaneous push and pop when not full and not empty leaves fifo_level unchanged. fifo_level counts accepted entries not yet popped.
- FSM states are IDLE and DRIVE.
  - IDLE: j=k=0. At an edge with FIFO non-empty: pop, load j/k from op, set cnt=cmd_len, go to DRIVE. A command accepted at edge P0 therefore drives j/k starting after edge P1 (2-edge latency when idle).
  - DRIVE: at each edge with cnt>0, cnt decrements and j/k are held.
  - DRIVE with cnt==0 at an edge: done<=1. If the FIFO is non-empty, pop and load the next command (back-to-back, no idle gap, stay in DRIVE). Otherwise j=k=0 and go to IDLE.
  - done is low at every other edge.
- The counter wraps never; cmd_len=max drives 2^CNT_W cycles.
- q_model updates at every edge from the current registered j/k: 00 hold, 01 ->0, 10 ->1, 11 ->~q_model. This matches the value the downstream flop captures at the same edge.
- busy = (state==DRIVE).

Test Plan:
1. Reset: hold rst 2 cycles, release -> j=k=0, q_model=0, busy=0, done=0, fifo_level=0, cmd_ready=1. Assert rst with cmd_valid=1 -> nothing queued.
2. SET, len=2, accepted at edge P0 -> j=1,k=0 after edges P1..P3. q_model=1 after P2. done=1 only after P4, where j=k=0, busy=0.
3. TOGGLE, len=3, from q_model=0 -> j=k=1 for 4 cycles. q_model sequence after successive edges is 1,0,1,0. done single pulse.
4. Back-to-back: push SET len=0 then RESET len=0 on consecutive cycles -> jk=10 for one cycle, immediately jk=01 for one cycle, no 00 gap. done high two consecutive cycles. q_model goes 1 then 0.
5. Full: issue HOLD len=15, then push 5 more commands -> after 4 are queued, fifo_level=4 and cmd_ready=0. The 5th is accepted only at the edge after the next pop; no entry lost or duplicated.
6. Reset mid-operation: rst during a TOGGLE len=15 with 2 queued -> after the reset edge, j=k=0, busy=0, fifo_level=0, q_model=0. No done pulse. The next command behaves as in scenario 2.
